// File: rtl/mp64_sram_copy.sv
// rtl/mp64_sram_copy.sv - row copy engine on a wide single-port SRAM (RD/WR ping-pong, 2 cycles per row)
// Optional row fill mode under macro MP64_SRAM_COPY_FILL_EN.
module mp64_sram_copy #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_fill,
    input  logic [63:0]       cmd_pattern,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_FIN} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  k_q, k_d, len_q, len_d, k_inc;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_ce_q, m_ce_d, m_we_q, m_we_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              row_next_rd;
`ifdef MP64_SRAM_COPY_FILL_EN
    logic              fill_q, fill_d;
    logic [63:0]       pattern_q, pattern_d;
`else
    logic              unused_fill;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        k_inc   = k_q + LEN_W'(1);
`ifdef MP64_SRAM_COPY_FILL_EN
        fill_d      = fill_q;
        pattern_d   = pattern_q;
        row_next_rd = !fill_q;
`else
        row_next_rd = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    len_d = cmd_len;
                    k_d   = '0;
`ifdef MP64_SRAM_COPY_FILL_EN
                    fill_d    = cmd_fill;
                    pattern_d = cmd_pattern;
                    if (cmd_len == '0)   state_d = ST_FIN;
                    else if (cmd_fill)   state_d = ST_WR;
                    else                 state_d = ST_RD;
`else
                    state_d = (cmd_len == '0) ? ST_FIN : ST_RD;
`endif
                end
            end
            ST_RD: state_d = abort ? ST_IDLE : ST_WR;
            ST_WR: begin
                k_d = k_inc;
                if (abort)              state_d = ST_IDLE;
                else if (k_inc < len_q) state_d = row_next_rd ? ST_RD : ST_WR;
                else                    state_d = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        m_ce_d   = (state_d == ST_RD) || (state_d == ST_WR);
        m_we_d   = (state_d == ST_WR);
        m_addr_d = (state_d == ST_RD) ? src_d + ADDR_W'(k_d) : dst_d + ADDR_W'(k_d);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            m_addr_q  <= '0;
            m_ce_q    <= 1'b0;
            m_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MP64_SRAM_COPY_FILL_EN
            fill_q    <= 1'b0;
            pattern_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            len_q     <= len_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            m_addr_q  <= m_addr_d;
            m_ce_q    <= m_ce_d;
            m_we_q    <= m_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MP64_SRAM_COPY_FILL_EN
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
`endif
        end
    end

    // Gated by rst_n so the port reads 0 throughout reset and 1 as soon as it lifts.
    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign m_ce      = m_ce_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;

`ifdef MP64_SRAM_COPY_FILL_EN
    assign m_wdata = fill_q ? {(DATA_W/64){pattern_q}} : m_rdata;
`else
    assign m_wdata     = m_rdata;
    assign unused_fill = ^{cmd_fill, cmd_pattern};
`endif

endmodule

// File: tb/tb_mp64_sram_copy.sv
// tb/tb_mp64_sram_copy.sv - bench for mp64_sram_copy with SRAM model and row-level reference memory
module tb_mp64_sram_copy;
    localparam int AW    = 14;
    localparam int DW    = 512;
    localparam int LW    = 15;
    localparam int NROWS = 1 << AW;
    localparam int NOCUT = 1 << 30;
`ifdef MP64_SRAM_COPY_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_fill, abort, busy, done, m_ce, m_we;
    logic [AW-1:0] cmd_src, cmd_dst, m_addr;
    logic [LW-1:0] cmd_len;
    logic [63:0]   cmd_pattern;
    logic [DW-1:0] m_wdata, m_rdata;

    logic [DW-1:0] mem     [NROWS];
    logic [DW-1:0] ref_mem [NROWS];
    logic          s_ce, s_we, init_pulse;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [31:0]   seed;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    mp64_sram_copy #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .cmd_pattern(cmd_pattern), .abort(abort), .busy(busy), .done(done),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    function automatic logic [DW-1:0] row_init(input int i, input logic [31:0] s);
        logic [DW-1:0] r;
        logic [31:0]   x;
        r = '0;
        for (int j = 0; j < DW / 32; j++) begin
            x = s ^ (i * 32'h9E3779B1) ^ (j * 32'h85EBCA6B);
            x = x ^ (x >> 15);
            x = x * 32'h2C1B3C6D;
            x = x ^ (x >> 12);
            r[j*32 +: 32] = x;
        end
        return r;
    endfunction

    // SRAM: port sampled mid-cycle, applied at the edge; read data lands one cycle later.
    always @(negedge clk) begin
        s_ce    = m_ce;
        s_we    = m_we;
        s_addr  = m_addr;
        s_wdata = m_wdata;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (init_pulse) begin
            for (int i = 0; i < NROWS; i++) mem[i] <= row_init(i, seed);
        end else if (s_ce) begin
            if (s_we) mem[s_addr] <= s_wdata;
            else      m_rdata     <= mem[s_addr];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                           input bit fill, input logic [63:0] pat, input int abort_n,
                           input bit abort_acc, input int rst_at);
        logic [30:0]   exp_q[$];
        logic [30:0]   got_q[$];
        logic [AW-1:0] a;
        int  last, cut, exp_done, nwr, done_n, n_done, acc, n, w, bad;
        bit  fe;

        fe   = fill && FILL_EN && (len > 0);
        last = (len == 0) ? 0 : (fe ? len : 2 * len);
        cut  = NOCUT;
        if (abort_n >= 1 && abort_n <= last) cut = abort_n;
        if (rst_at >= 1 && rst_at <= last)   cut = rst_at;

        nwr = 0;
        for (int k = 0; k < len; k++) begin
            if (fe) begin
                if (k + 1 <= cut) begin
                    a = dst + AW'(k);
                    exp_q.push_back({16'(k + 1), 1'b1, a});
                    nwr++;
                end
            end else begin
                if (2 * k + 1 <= cut) begin
                    a = src + AW'(k);
                    exp_q.push_back({16'(2 * k + 1), 1'b0, a});
                end
                if (2 * k + 2 <= cut) begin
                    a = dst + AW'(k);
                    exp_q.push_back({16'(2 * k + 2), 1'b1, a});
                    nwr++;
                end
            end
        end
        exp_done = (cut == NOCUT) ? last + 1 : -1;
        for (int k = 0; k < nwr; k++)
            ref_mem[dst + AW'(k)] = fe ? {(DW/64){pat}} : ref_mem[src + AW'(k)];

        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_len     = LW'(len);
        cmd_fill    = fill;
        cmd_pattern = pat;
        abort       = abort_acc;
        acc         = cyc;
        @(negedge clk);
        cmd_valid   = 1'b0;
        abort       = 1'b0;
        cmd_src     = AW'($urandom);
        cmd_dst     = AW'($urandom);
        cmd_len     = LW'($urandom);
        cmd_fill    = 1'($urandom);
        cmd_pattern = {$urandom, $urandom};

        done_n = -1;
        n_done = 0;
        for (int it = 0; it < 200; it++) begin
            n = cyc - acc;
            if (m_ce) got_q.push_back({16'(n), m_we, m_addr});
            if (done) begin
                n_done++;
                if (done_n < 0) done_n = n;
            end
            if (exp_done >= 0 && n == exp_done) chk("ready_in_fin", cmd_ready, 0);
            if (exp_done >= 0 && n == exp_done + 1) begin
                chk("done_one_cycle", done, 0);
                chk("ready_after_fin", cmd_ready, 1);
                break;
            end
            if (cut != NOCUT && cut == abort_n && n == cut + 1) begin
                chk("ready_after_abort", cmd_ready, 1);
                chk("busy_after_abort", busy, 0);
                break;
            end
            if (cut != NOCUT && cut == rst_at && n == cut) begin
                rst_n = 1'b0;
                #1;
                chk("rst_m_ce", m_ce, 0);
                chk("rst_m_we", m_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ready", cmd_ready, 0);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk("ready_after_reset", cmd_ready, 1);
                break;
            end
            if (n > last + 4) begin
                chk("timeout", n, last + 4);
                break;
            end
            abort = (n == abort_n);
            @(negedge clk);
        end
        abort = 1'b0;

        chk("n_access", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("access", got_q[i], exp_q[i]);
        chk("done_cycle", done_n, exp_done);
        chk("done_pulses", n_done, (exp_done < 0) ? 0 : 1);
        bad = 0;
        for (int i = 0; i < NROWS; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_rows_bad", bad, 0);
    endtask

    initial begin
        logic [DW-1:0] row_a;
        int len, mode, ab;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_len     = '0;
        cmd_fill    = 1'b0;
        cmd_pattern = '0;
        abort       = 1'b0;
        seed        = $urandom;
        init_pulse  = 1'b1;
        repeat (2) @(negedge clk);
        init_pulse = 1'b0;
        for (int i = 0; i < NROWS; i++) ref_mem[i] = row_init(i, seed);

        chk("reset_ready", cmd_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_m_ce", m_ce, 0);
        chk("reset_m_we", m_we, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", cmd_ready, 1);
        @(negedge clk);

        run_cmd(14'h0010, 14'h0080, 4, 1'b0, 64'h0, -1, 1'b0, -1);
        run_cmd(14'h0123, 14'h0456, 0, 1'b0, 64'h0, -1, 1'b0, -1);
        run_cmd(14'h3FFE, 14'h0010, 3, 1'b0, 64'h0, -1, 1'b0, -1);
        row_a = ref_mem[5];
        run_cmd(14'h0005, 14'h0006, 3, 1'b0, 64'h0, -1, 1'b0, -1);
        chk("overlap_row6", mem[6], row_a);
        chk("overlap_row7", mem[7], row_a);
        chk("overlap_row8", mem[8], row_a);
        run_cmd(14'h0100, 14'h0200, 8, 1'b0, 64'h0, 6, 1'b0, -1);
        run_cmd(14'h0300, 14'h0400, 8, 1'b0, 64'h0, -1, 1'b0, 5);
        run_cmd(14'h0040, 14'h0020, 2, 1'b1, 64'hDEADBEEF00C0FFEE, -1, 1'b0, -1);
        run_cmd(14'h0500, 14'h0600, 2, 1'b0, 64'h0, -1, 1'b1, -1);
        run_cmd(14'h0700, 14'h0800, 2, 1'b0, 64'h0, 5, 1'b0, -1);

        for (int r = 0; r < 12; r++) begin
            len  = int'($urandom_range(0, 9));
            mode = int'($urandom_range(0, 2));
            ab   = (mode == 1) ? int'($urandom_range(1, 2 * len + 2)) : -1;
            run_cmd(AW'($urandom), AW'($urandom), len, 1'($urandom),
                    {$urandom, $urandom}, ab, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
